// File: rtl/wreg_dest_pipe_if.sv
// wreg_dest_pipe_if: decode-side bundle for the write-destination pipe.
//   master: the decode stage; it drives the instruction fields, the stall
//           and flush controls, and the source registers used for the
//           hazard compare. It receives the writeback and hazard results.
//   slave : the pipe itself.
//   Signals: rt, rd, regdst, wreg, jal, stall, flush, rs_q, rt_q (decode ->
//            pipe); wn, we, hz_rs, hz_rt, inflight (pipe -> decode).
interface wreg_dest_pipe_if #(parameter int AW = 5) ();
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic          regdst;
  logic          wreg;
  logic          jal;
  logic          stall;
  logic          flush;
  logic [AW-1:0] rs_q;
  logic [AW-1:0] rt_q;
  logic [AW-1:0] wn;
  logic          we;
  logic          hz_rs;
  logic          hz_rt;
  logic [3:0]    inflight;

  modport master (
    output rt, rd, regdst, wreg, jal, stall, flush, rs_q, rt_q,
    input  wn, we, hz_rs, hz_rt, inflight
  );

  modport slave (
    input  rt, rd, regdst, wreg, jal, stall, flush, rs_q, rt_q,
    output wn, we, hz_rs, hz_rt, inflight
  );
endinterface

// File: rtl/wreg_dest_pipe.sv
// wreg_dest_pipe: carries the register-file write destination of each
// decoded instruction from decode to writeback through DEPTH stages.
//   clk   : rising-edge clock
//   clrn  : asynchronous active-low reset
//   bus   : wreg_dest_pipe_if.slave
//           rt/rd/regdst/wreg/jal form the entry, stall holds all stages,
//           flush replaces the decode entry with a bubble (wins over stall),
//           rs_q/rt_q are compared against every in-flight destination.
//           wn/we are the registered last stage, inflight counts the valid
//           entries.
// Optional feature macro: WREG_HAZARD_EN builds the hz_rs/hz_rt compare;
// without it both outputs are tied low.
module wreg_dest_pipe #(
  parameter int            AW       = 5,
  parameter int            DEPTH    = 3,
  parameter logic [AW-1:0] LINK_REG = '1
) (
  input logic             clk,
  input logic             clrn,
  wreg_dest_pipe_if.slave bus
);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] d;
  } ent_t;

  ent_t [DEPTH-1:0] pipe;
  ent_t             in_ent;
  ent_t             ld_ent;
  logic [AW-1:0]    dsel;
  logic             move;
  logic             inc;
  logic             dec;
  logic [3:0]       cnt;

  // An entry for r0 is never valid, and an invalid entry always carries
  // dest 0 so downstream compares never see stale register numbers.
  always_comb begin
    dsel     = bus.jal ? LINK_REG : (bus.regdst ? bus.rd : bus.rt);
    in_ent.v = (bus.wreg | bus.jal) && (dsel != '0);
    in_ent.d = in_ent.v ? dsel : '0;
  end

  // Flush still lets the older stages drain, even under stall.
  assign move   = bus.flush | ~bus.stall;
  assign ld_ent = bus.flush ? '0 : in_ent;
  assign inc    = ld_ent.v;
  assign dec    = pipe[DEPTH-1].v;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pipe <= '0;
      cnt  <= '0;
    end else if (move) begin
      pipe[0] <= ld_ent;
      for (int i = DEPTH - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      case ({inc, dec})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.wn       = pipe[DEPTH-1].d;
  assign bus.we       = pipe[DEPTH-1].v;
  assign bus.inflight = cnt;

`ifdef WREG_HAZARD_EN
  always_comb begin
    bus.hz_rs = 1'b0;
    bus.hz_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe[i].v && pipe[i].d == bus.rs_q) bus.hz_rs = 1'b1;
      if (pipe[i].v && pipe[i].d == bus.rt_q) bus.hz_rt = 1'b1;
    end
    // r0 is never a real dependency
    if (bus.rs_q == '0) bus.hz_rs = 1'b0;
    if (bus.rt_q == '0) bus.hz_rt = 1'b0;
  end
`else
  logic unused_hz_src;
  assign unused_hz_src = ^{bus.rs_q, bus.rt_q};
  assign bus.hz_rs     = 1'b0;
  assign bus.hz_rt     = 1'b0;
`endif

endmodule

// File: tb/tb_wreg_dest_pipe.sv
// tb_wreg_dest_pipe: directed and random stimulus against a queue-based
// reference model of the destination pipe (AW=5, DEPTH=3).
module tb_wreg_dest_pipe;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int LINK  = (1 << AW) - 1;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  wreg_dest_pipe_if #(.AW(AW)) bus ();

  wreg_dest_pipe #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  typedef struct {
    bit v;
    int d;
  } ment_t;

  // Front of the queue is the decode stage, back is writeback.
  ment_t mq[$];
  int    nchk = 0;
  int    nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    ment_t b;
    b.v = 0;
    b.d = 0;
    mq.delete();
    repeat (DEPTH) mq.push_back(b);
  endfunction

  function automatic int model_count();
    int n = 0;
    foreach (mq[i]) if (mq[i].v) n++;
    return n;
  endfunction

  function automatic bit model_hz(input int src);
`ifdef WREG_HAZARD_EN
    if (src == 0) return 0;
    foreach (mq[i]) if (mq[i].v && mq[i].d == src) return 1;
    return 0;
`else
    return (src < 0);
`endif
  endfunction

  // One full clock: drive at the falling edge, check the combinational
  // hazard outputs, let the rising edge happen, advance the model, then
  // check the registered outputs at the next falling edge.
  task automatic cyc(input int rt_, input int rd_, input bit regdst_, input bit wreg_,
                     input bit jal_, input bit stall_, input bit flush_,
                     input int rsq, input int rtq);
    ment_t e;
    bus.rt     = rt_[AW-1:0];
    bus.rd     = rd_[AW-1:0];
    bus.regdst = regdst_;
    bus.wreg   = wreg_;
    bus.jal    = jal_;
    bus.stall  = stall_;
    bus.flush  = flush_;
    bus.rs_q   = rsq[AW-1:0];
    bus.rt_q   = rtq[AW-1:0];
    #1;
    chk("hz_rs", {31'b0, bus.hz_rs}, {31'b0, model_hz(rsq)});
    chk("hz_rt", {31'b0, bus.hz_rt}, {31'b0, model_hz(rtq)});
    @(posedge clk);
    if (flush_ || !stall_) begin
      e.v = 0;
      e.d = 0;
      if (!flush_) begin
        e.d = jal_ ? LINK : (regdst_ ? rd_ : rt_);
        e.v = (wreg_ || jal_) && (e.d != 0);
        if (!e.v) e.d = 0;
      end
      mq.push_front(e);
      void'(mq.pop_back());
    end
    @(negedge clk);
    chk("wn", 32'(bus.wn), mq[DEPTH-1].d);
    chk("we", {31'b0, bus.we}, {31'b0, mq[DEPTH-1].v});
    chk("inflight", 32'(bus.inflight), model_count());
  endtask

  task automatic idle(input int rsq = 0);
    cyc(0, 0, 0, 0, 0, 0, 0, rsq, 0);
  endtask

  initial begin
    clrn = 1'b0;
    bus.rt = '0; bus.rd = '0; bus.regdst = 0; bus.wreg = 0; bus.jal = 0;
    bus.stall = 0; bus.flush = 0; bus.rs_q = '0; bus.rt_q = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_wn", 32'(bus.wn), 0);
    chk("rst_we", {31'b0, bus.we}, 0);
    chk("rst_inflight", 32'(bus.inflight), 0);
    clrn = 1'b1;

    // rd=7 appears exactly DEPTH edges later, then leaves
    cyc(0, 7, 1, 1, 0, 0, 0, 0, 0);
    idle(); idle();
    chk("r31_wn", 32'(bus.wn), 7);
    chk("r31_we", {31'b0, bus.we}, 1);
    idle();
    chk("r31_we_off", {31'b0, bus.we}, 0);

    // jal without wreg links to the top register
    cyc(4, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("r32_cnt1", 32'(bus.inflight), 1);
    idle(); idle();
    chk("r32_wn", 32'(bus.wn), LINK);
    chk("r32_we", {31'b0, bus.we}, 1);
    idle();
    chk("r32_cnt0", 32'(bus.inflight), 0);

    // write to r0 is dropped
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(); idle();
    chk("r33_we", {31'b0, bus.we}, 0);
    chk("r33_cnt", 32'(bus.inflight), 0);

    // two stall cycles delay dest 9 by two
    cyc(0, 9, 1, 1, 0, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 9, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 9, 0);
    idle(9);
    chk("r34_early", {31'b0, bus.we}, 0);
    idle(9);
    chk("r34_wn", 32'(bus.wn), 9);
    chk("r34_we", {31'b0, bus.we}, 1);
    idle();

    // flush beats stall: dest 5 is lost, dest 3 still drains
    cyc(0, 3, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 5, 1, 1, 0, 1, 1, 0, 0);
    idle();
    chk("r35_old_wn", 32'(bus.wn), 3);
    chk("r35_old_we", {31'b0, bus.we}, 1);
    idle();
    chk("r35_lost", {31'b0, bus.we}, 0);
    idle();

    // asynchronous reset with three entries in flight
    cyc(0, 10, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 11, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 12, 1, 1, 0, 0, 0, 0, 0);
    chk("r36_pre_cnt", 32'(bus.inflight), 3);
    bus.rs_q = 5'd11;
    bus.rt_q = 5'd12;
    clrn = 1'b0;
    #1;
    chk("r36_wn", 32'(bus.wn), 0);
    chk("r36_we", {31'b0, bus.we}, 0);
    chk("r36_cnt", 32'(bus.inflight), 0);
    chk("r36_hz_rs", {31'b0, bus.hz_rs}, 0);
    chk("r36_hz_rt", {31'b0, bus.hz_rt}, 0);
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    cyc(0, 13, 1, 1, 0, 0, 0, 0, 0);
    idle(); idle();
    chk("r29_wn", 32'(bus.wn), 13);
    chk("r29_we", {31'b0, bus.we}, 1);

    // random traffic, small register range to provoke r0 and hazard hits
    repeat (300) begin
      cyc($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
          $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/wreg_dest_pipe.md
WREG_DEST_PIPE -- requirements
Module: wreg_dest_pipe

Interface
REQ-001 Parameter AW, default 5, register-number width in bits (minimum 2).
REQ-002 Parameter DEPTH, default 3, number of pipeline stages from decode to writeback (minimum 1, maximum 8).
REQ-003 Parameter LINK_REG, default all-ones of width AW (31 at AW=5), link register number forced on jal.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 clrn  input  1  reset; asynchronous and active-low.
REQ-006 rt  input  AW  rt field of the decoded instruction.
REQ-007 rd  input  AW  rd field of the decoded instruction.
REQ-008 regdst  input  1  1 selects rd as destination, 0 selects rt.
REQ-009 wreg  input  1  decoded instruction writes the register file.
REQ-010 jal  input  1  decoded instruction is a jump-and-link.
REQ-011 stall  input  1  hold all stages.
REQ-012 flush  input  1  replace the decode-stage entry with a bubble.
REQ-013 rs_q, rt_q  input  AW each  source registers of the next decoded instruction, for hazard compare.
REQ-014 wn  output  AW  writeback destination register number.
REQ-015 we  output  1  writeback enable.
REQ-016 hz_rs, hz_rt  output  1 each  source matches an in-flight destination.
REQ-017 inflight  output  4  count of valid entries in stages 0..DEPTH-1.

Function
REQ-018 Entry formation SHALL be combinational: dest = jal ? LINK_REG : (regdst ? rd : rt), and valid = (wreg | jal) & (dest != 0).
REQ-019 A nonzero valid destination SHALL never be generated for register 0; dest SHALL be forced to 0 whenever valid = 0.
REQ-020 With stall=0 and flush=0, stage 0 SHALL load the formed entry and each stage i SHALL load stage i-1, giving a latency of exactly DEPTH cycles to wn/we.
REQ-021 With stall=1 and flush=0, all stages SHALL hold their contents.
REQ-022 With flush=1, stage 0 SHALL load a bubble (valid=0, dest=0) and stages 1..DEPTH-1 SHALL advance, regardless of stall; flush has priority.
REQ-023 wn SHALL equal the dest of stage DEPTH-1, and we SHALL equal its valid bit, both as registered values.
REQ-024 hz_rs SHALL be 1 iff rs_q != 0 and any stage 0..DEPTH-1 is valid with dest == rs_q; hz_rt SHALL be defined identically using rt_q; both are combinational.
REQ-025 inflight SHALL be a registered counter updated each cycle to the number of valid entries after the update; it SHALL not exceed DEPTH.
REQ-026 Counter arithmetic: increment on a valid entry in, decrement on a valid entry out of stage DEPTH-1; simultaneous in and out SHALL leave the count unchanged; no change while stalled.
REQ-027 jal with wreg=0 SHALL still produce a valid entry to LINK_REG.

Reset
REQ-028 clrn=0 SHALL asynchronously clear all stage valid bits and dests, wn=0, we=0, and inflight=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries; the first entry accepted after release SHALL appear at wn/we DEPTH cycles later.

Configuration
REQ-030 Macro WREG_HAZARD_EN: when defined, REQ-024 compare logic is built; when undefined, hz_rs and hz_rt SHALL be tied to 0 and the ports SHALL remain present.

Verification
REQ-031 Reset release, then regdst=1, rd=7, wreg=1 for one cycle -> wn=7 and we=1 exactly 3 cycles later (DEPTH=3), then we=0.
REQ-032 jal=1, wreg=0, rt=4 -> wn=31, we=1 after 3 cycles; inflight steps to 1, then back to 0 after exit.
REQ-033 wreg=1, regdst=0, rt=0 -> we stays 0, and hz_rt stays 0 with rt_q=0.
REQ-034 Issue dest 9, then stall=1 for 2 cycles -> wn=9 delayed by 2 extra cycles; hz_rs=1 with rs_q=9 throughout the stall.
REQ-035 Issue dest 5 with flush=1 and stall=1 in the same cycle -> stage-0 entry is lost and we never pulses for 5; older entries still drain.
REQ-036 Drive clrn=0 with 3 entries in flight -> wn=0, we=0, and inflight=0 immediately without a clock edge; with WREG_HAZARD_EN undefined, hz_rs=hz_rt=0 for all stimulus.
